// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: forwards EX/MEM and WB results, detects load-use hazards,
// conditions operand B and registers everything for the ALU behind a valid/ready handshake.
module ex_operand_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [REG_AW-1:0] rs1_idx,
    input  logic [REG_AW-1:0] rs2_idx,
    input  logic [REG_AW-1:0] rd_idx,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [DATA_W-1:0] imm,
    input  logic              alu_src_imm,
    input  logic [2:0]        alu_op_in,
    input  logic              reg_write_in,
    input  logic              is_load_in,
    input  logic              exm_valid,
    input  logic              exm_reg_write,
    input  logic              exm_is_load,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [2:0]        ALUOp,
    output logic [REG_AW-1:0] rd_out,
    output logic              reg_write_out,
    output logic              is_load_out,
    output logic              op_illegal,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [2:0]        OP_SHL     = 3'b011;
    localparam logic [2:0]        OP_SHR     = 3'b100;
    localparam logic [DATA_W-1:0] SHAMT_MASK = {{(DATA_W-SHAMT_W){1'b0}}, {SHAMT_W{1'b1}}};

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              is_load_q, is_load_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic              exm_fwd_ok;
    logic [DATA_W-1:0] rs1_fwd, rs2_fwd, b_raw;
    logic              hazard, accept, slot_free;

    // Operand forwarding: EX/MEM wins over WB; loads in EX/MEM have no data yet.
    assign exm_fwd_ok = exm_valid && exm_reg_write && !exm_is_load;

    always_comb begin
        rs1_fwd = rs1_data;
        if (rs1_idx == '0)                             rs1_fwd = '0;
        else if (exm_fwd_ok && (exm_rd == rs1_idx))    rs1_fwd = exm_result;
        else if (wb_reg_write && (wb_rd == rs1_idx))   rs1_fwd = wb_data;

        rs2_fwd = rs2_data;
        if (rs2_idx == '0)                             rs2_fwd = '0;
        else if (exm_fwd_ok && (exm_rd == rs2_idx))    rs2_fwd = exm_result;
        else if (wb_reg_write && (wb_rd == rs2_idx))   rs2_fwd = wb_data;
    end

    assign hazard = in_valid && exm_valid && exm_is_load && (exm_rd != '0) &&
                    ((exm_rd == rs1_idx) || (!alu_src_imm && (exm_rd == rs2_idx)));

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = slot_free && !hazard;
    assign accept    = in_valid && in_ready;

    assign b_raw = alu_src_imm ? imm : rs2_fwd;

    // Next-state: flush > accept > bubble/drain > hold.
    always_comb begin
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        is_load_d   = is_load_q;
        illegal_d   = illegal_q;
        stall_d     = stall_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            a_d         = rs1_fwd;
            b_d         = ((alu_op_in == OP_SHL) || (alu_op_in == OP_SHR)) ? (b_raw & SHAMT_MASK) : b_raw;
            op_d        = alu_op_in;
            rd_d        = rd_idx;
            reg_write_d = reg_write_in;
            is_load_d   = is_load_in;
            illegal_d   = (alu_op_in == 3'b101) || (alu_op_in == 3'b110) || (alu_op_in == 3'b111);
        end else if (hazard && slot_free) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (hazard && !flush && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            is_load_q   <= 1'b0;
            illegal_q   <= 1'b0;
            stall_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            is_load_q   <= is_load_d;
            illegal_q   <= illegal_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign A             = a_q;
    assign B             = b_q;
    assign ALUOp         = op_q;
    assign rd_out        = rd_q;
    assign reg_write_out = reg_write_q;
    assign is_load_out   = is_load_q;
    assign op_illegal    = illegal_q;
    assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: forwarding, load-use stall, operand B
// conditioning, backpressure, flush, stall saturation and asynchronous reset.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, flush;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic [31:0] rs1_data, rs2_data, imm;
    logic        alu_src_imm;
    logic [2:0]  alu_op_in;
    logic        reg_write_in, is_load_in;
    logic        exm_valid, exm_reg_write, exm_is_load;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] A, B;
    logic [2:0]  ALUOp;
    logic [4:0]  rd_out;
    logic        reg_write_out, is_load_out, op_illegal;
    logic [7:0]  stall_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .alu_src_imm(alu_src_imm), .alu_op_in(alu_op_in),
        .reg_write_in(reg_write_in), .is_load_in(is_load_in),
        .exm_valid(exm_valid), .exm_reg_write(exm_reg_write), .exm_is_load(exm_is_load),
        .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .ALUOp(ALUOp), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .is_load_out(is_load_out),
        .op_illegal(op_illegal), .stall_cnt(stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im,
                             input logic src_imm, input logic [2:0] op);
        rs1_idx = r1; rs2_idx = r2; rd_idx = rd;
        rs1_data = d1; rs2_data = d2; imm = im;
        alu_src_imm = src_imm; alu_op_in = op;
    endtask

    task automatic clear_exm_wb();
        exm_valid = 1'b0; exm_reg_write = 1'b0; exm_is_load = 1'b0;
        exm_rd = '0; exm_result = '0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        reg_write_in = 1'b0; is_load_in = 1'b0;
        set_instr(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000);
        clear_exm_wb();
        #3;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %h exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (A !== 32'h0 || B !== 32'h0) $display("FAIL reset_ab: got A=%h B=%h exp 0", A, B); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 8'h0 || op_illegal !== 1'b0) $display("FAIL reset_cnt: got cnt=%h ill=%h exp 0", stall_cnt, op_illegal); else pass_cnt++;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_empty: got %h exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %h exp 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_basic();
        set_instr(5'd3, 5'd4, 5'd7, 32'h10, 32'h20, 32'h0, 1'b0, 3'b001);
        reg_write_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_ready: got %h exp 1", in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %h exp 1", out_valid); else pass_cnt++;
        total_cnt++; if (A !== 32'h10 || B !== 32'h20) $display("FAIL basic_ab: got A=%h B=%h exp 10 20", A, B); else pass_cnt++;
        total_cnt++; if (ALUOp !== 3'b001 || rd_out !== 5'd7 || reg_write_out !== 1'b1) $display("FAIL basic_ctl: got op=%h rd=%h rw=%h exp 1 7 1", ALUOp, rd_out, reg_write_out); else pass_cnt++;
    endtask

    task automatic test_forwarding();
        exm_valid = 1'b1; exm_reg_write = 1'b1; exm_rd = 5'd3; exm_result = 32'h55;
        wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 32'h66;
        tick();
        total_cnt++; if (A !== 32'h55 || B !== 32'h20) $display("FAIL fwd_exm: got A=%h B=%h exp 55 20", A, B); else pass_cnt++;
        exm_reg_write = 1'b0;
        tick();
        total_cnt++; if (A !== 32'h66) $display("FAIL fwd_wb: got %h exp 66", A); else pass_cnt++;
        rs1_idx = 5'd0;
        tick();
        total_cnt++; if (A !== 32'h0) $display("FAIL fwd_r0: got %h exp 0", A); else pass_cnt++;
        rs1_idx = 5'd3; exm_reg_write = 1'b1; wb_rd = 5'd4;
        tick();
        total_cnt++; if (A !== 32'h55 || B !== 32'h66) $display("FAIL fwd_split: got A=%h B=%h exp 55 66", A, B); else pass_cnt++;
        clear_exm_wb();
    endtask

    task automatic test_load_use();
        set_instr(5'd3, 5'd4, 5'd8, 32'h10, 32'h20, 32'h0, 1'b0, 3'b001);
        exm_valid = 1'b1; exm_reg_write = 1'b1; exm_is_load = 1'b1; exm_rd = 5'd4; exm_result = 32'h77;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL lu_ready: got %h exp 0", in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0 || stall_cnt !== 8'd1) $display("FAIL lu_bubble: got v=%h cnt=%0d exp 0 1", out_valid, stall_cnt); else pass_cnt++;
        exm_is_load = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL lu_release: got %h exp 1", in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b1 || A !== 32'h10 || B !== 32'h77 || rd_out !== 5'd8) $display("FAIL lu_accept: got v=%h A=%h B=%h rd=%0d exp 1 10 77 8", out_valid, A, B, rd_out); else pass_cnt++;
        exm_is_load = 1'b1; alu_src_imm = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL lu_imm_nohaz: got %h exp 1", in_ready); else pass_cnt++;
        tick();
        clear_exm_wb();
    endtask

    task automatic test_shift_imm();
        set_instr(5'd3, 5'd4, 5'd9, 32'h10, 32'h20, 32'hFFFF_FF23, 1'b1, 3'b011);
        is_load_in = 1'b1;
        tick();
        total_cnt++; if (B !== 32'h3 || ALUOp !== 3'b011 || is_load_out !== 1'b1 || op_illegal !== 1'b0) $display("FAIL shl_mask: got B=%h op=%h ld=%h ill=%h exp 3 3 1 0", B, ALUOp, is_load_out, op_illegal); else pass_cnt++;
        alu_op_in = 3'b100;
        tick();
        total_cnt++; if (B !== 32'h3) $display("FAIL shr_mask: got %h exp 3", B); else pass_cnt++;
        alu_op_in = 3'b010;
        tick();
        total_cnt++; if (B !== 32'hFFFF_FF23) $display("FAIL nonshift_imm: got %h exp ffffff23", B); else pass_cnt++;
        alu_op_in = 3'b101;
        tick();
        total_cnt++; if (op_illegal !== 1'b1 || ALUOp !== 3'b101 || B !== 32'hFFFF_FF23) $display("FAIL illegal_101: got ill=%h op=%h B=%h exp 1 5 ffffff23", op_illegal, ALUOp, B); else pass_cnt++;
        alu_op_in = 3'b111;
        tick();
        total_cnt++; if (op_illegal !== 1'b1 || ALUOp !== 3'b111) $display("FAIL illegal_111: got ill=%h op=%h exp 1 7", op_illegal, ALUOp); else pass_cnt++;
        alu_op_in = 3'b011; alu_src_imm = 1'b0; is_load_in = 1'b0;
        tick();
        total_cnt++; if (B !== 32'h0 || op_illegal !== 1'b0) $display("FAIL shl_reg: got B=%h ill=%h exp 0 0", B, op_illegal); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        set_instr(5'd3, 5'd4, 5'd10, 32'h10, 32'h20, 32'h0, 1'b0, 3'b001);
        tick();
        total_cnt++; if (out_valid !== 1'b1 || A !== 32'h10) $display("FAIL bp_first: got v=%h A=%h exp 1 10", out_valid, A); else pass_cnt++;
        out_ready = 1'b0;
        set_instr(5'd5, 5'd6, 5'd11, 32'h99, 32'hAA, 32'h0, 1'b0, 3'b010);
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready%0d: got %h exp 0", i, in_ready); else pass_cnt++;
            tick();
            total_cnt++; if (out_valid !== 1'b1 || A !== 32'h10 || B !== 32'h20 || ALUOp !== 3'b001) $display("FAIL bp_hold%0d: got v=%h A=%h B=%h op=%h exp 1 10 20 1", i, out_valid, A, B, ALUOp); else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release: got %h exp 1", in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (A !== 32'h99 || B !== 32'hAA || ALUOp !== 3'b010 || rd_out !== 5'd11) $display("FAIL bp_next: got A=%h B=%h op=%h rd=%0d exp 99 aa 2 11", A, B, ALUOp, rd_out); else pass_cnt++;
    endtask

    task automatic test_flush();
        set_instr(5'd3, 5'd4, 5'd12, 32'h10, 32'h20, 32'h0, 1'b0, 3'b001);
        flush = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_ready: got %h exp 1", in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_kill: got %h exp 0", out_valid); else pass_cnt++;
        exm_valid = 1'b1; exm_reg_write = 1'b1; exm_is_load = 1'b1; exm_rd = 5'd3;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_haz_ready: got %h exp 0", in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (stall_cnt !== 8'd1 || out_valid !== 1'b0) $display("FAIL flush_haz_cnt: got cnt=%0d v=%h exp 1 0", stall_cnt, out_valid); else pass_cnt++;
        flush = 1'b0;
    endtask

    task automatic test_stall_saturate();
        repeat (300) tick();
        total_cnt++; if (stall_cnt !== 8'd255) $display("FAIL stall_sat: got %0d exp 255", stall_cnt); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL stall_bubble: got v=%h rdy=%h exp 0 0", out_valid, in_ready); else pass_cnt++;
    endtask

    task automatic test_reset_mid_stall();
        #1;
        reset_n = 1'b0;
        #1;
        total_cnt++; if (A !== 32'h0 || B !== 32'h0 || ALUOp !== 3'b0 || rd_out !== 5'd0) $display("FAIL arst_data: got A=%h B=%h op=%h rd=%0d exp 0", A, B, ALUOp, rd_out); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 8'd0 || out_valid !== 1'b0 || reg_write_out !== 1'b0 || is_load_out !== 1'b0 || op_illegal !== 1'b0) $display("FAIL arst_ctl: got cnt=%0d v=%h rw=%h ld=%h ill=%h exp 0", stall_cnt, out_valid, reg_write_out, is_load_out, op_illegal); else pass_cnt++;
        in_valid = 1'b0;
        clear_exm_wb();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        total_cnt++; if (out_valid !== 1'b0 || stall_cnt !== 8'd0) $display("FAIL arst_after: got v=%h cnt=%0d exp 0 0", out_valid, stall_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forwarding();
        test_load_use();
        test_shift_imm();
        test_backpressure();
        test_flush();
        test_stall_saturate();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU.
- Each cycle it takes decoded instruction fields and register-file read data, and resolves data hazards: EX/MEM and WB forwarding, plus a load-use stall.
- It conditions operand B: immediate select, and a shift-amount mask for shift operations.
- It registers A, B, ALUOp and writeback control behind a valid/ready handshake. The ALU consumes these registered outputs combinationally in the next stage.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register index width. Register 0 is hardwired to zero.
- SHAMT_W, 5, number of low bits of B kept for shift operations.
- CNT_W, 8, width of the saturating stall counter.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode presents a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- flush  in  1  synchronous kill from branch resolution.
- rs1_idx, rs2_idx, rd_idx  in  REG_AW each  source and destination register indices.
- rs1_data, rs2_data  in  DATA_W each  register-file read data.
- imm  in  DATA_W  sign-extended immediate.
- alu_src_imm  in  1  when 1, B = imm and rs2 is unused.
- alu_op_in  in  3  ALU operation code.
- reg_write_in  in  1  instruction writes rd.
- is_load_in  in  1  instruction is a load.
- exm_valid, exm_reg_write, exm_is_load  in  1 each  EX/MEM stage status.
- exm_rd  in  REG_AW  EX/MEM destination register.
- exm_result  in  DATA_W  EX/MEM ALU result.
- wb_reg_write  in  1  WB stage writes a register.
- wb_rd  in  REG_AW  WB destination register.
- wb_data  in  DATA_W  WB write data.
- out_valid  out  1  registered outputs are valid for the ALU.
- out_ready  in  1  downstream can take the outputs.
- A, B  out  DATA_W each  registered ALU operands.
- ALUOp  out  3  registered ALU operation code.
- rd_out  out  REG_AW  registered destination register.
- reg_write_out, is_load_out  out  1 each  registered writeback control.
- op_illegal  out  1  registered flag: alu_op_in was 101, 110 or 111.
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - out_valid, A, B, ALUOp, rd_out, reg_write_out, is_load_out, op_illegal and stall_cnt all go to 0 immediately.
  - The stage is empty after reset release.
- Source read, per rs (rs1, rs2):
  - idx==0 gives 0.
  - Otherwise, if exm_valid && exm_reg_write && !exm_is_load && exm_rd==idx, use exm_result.
  - Otherwise, if wb_reg_write && wb_rd==idx, use wb_data.
  - Otherwise, use the register-file data.
  - EX/MEM has priority over WB.
- Load-use hazard = in_valid && exm_valid && exm_is_load && exm_rd!=0 && (exm_rd==rs1_idx || (!alu_src_imm && exm_rd==rs2_idx)).
- Ready: in_ready = (!out_valid || out_ready) && !hazard.
  - in_ready is combinational.
  - in_ready is independent of flush.
- Operand conditioning:
  - A = forwarded rs1.
  - Braw = alu_src_imm ? imm : forwarded rs2.
  - If alu_op_in is 011 or 100, B = Braw with bits above SHAMT_W-1 zeroed; otherwise B = Braw.
- Register update priority, evaluated each rising edge:
  1. flush: out_valid<=0. The incoming instruction is discarded even if in_valid. The data registers may hold stale values.
  2. Accept (in_valid && in_ready): load all output registers and set out_valid<=1. Latency from accept to out_valid is 1 cycle.
  3. Hazard with (!out_valid || out_ready): insert a bubble, out_valid<=0. The instruction remains at the input and is re-evaluated next cycle with fresh forwarding.
  4. out_valid && out_ready with no accept: out_valid<=0.
  5. Otherwise: hold. While out_valid && !out_ready, all outputs stay bit-stable.
- Back-to-back throughput: 1 instruction/cycle when out_ready is held high and no hazard occurs.
- op_illegal:
  - Illegal codes are passed through unchanged in ALUOp; the ALU yields 0 for them.
  - op_illegal=1 is registered with the instruction.
- stall_cnt: increments on each cycle in which hazard=1 and flush=0, saturates at 2^CNT_W-1, and is cleared only by reset.
- Reset mid-operation: the in-flight instruction is lost and no partial state survives.
- Simultaneous flush and hazard: the flush takes effect and the stall counter does not increment.

Test Plan:
- Reset then rs1=3 (data 0x10), rs2=4 (data 0x20), op=001, no forwarding, out_ready=1 -> next cycle out_valid=1, A=0x10, B=0x20, ALUOp=001.
- Same instruction with exm_rd=3 result 0x55 and wb_rd=3 data 0x66 -> A=0x55. Repeat with exm_reg_write=0 -> A=0x66. Repeat with rs1=0 -> A=0.
- exm_is_load=1, exm_rd=4, instruction reads rs2=4 with alu_src_imm=0 -> in_ready=0 for one cycle, out_valid=0 bubble, stall_cnt=1. Next cycle with exm_is_load=0 -> instruction accepted.
- op=011, alu_src_imm=1, imm=0xFFFF_FF23 -> B=0x0000_0003. Op=101 -> op_illegal=1, ALUOp=101.
- out_valid=1, out_ready=0 for 3 cycles with new in_valid -> in_ready=0 and A/B/ALUOp unchanged. Raising out_ready -> new instruction loads the next cycle.
- Accept and flush in the same cycle -> out_valid=0 next cycle. reset_n asserted mid-stall -> all outputs 0 asynchronously, stall_cnt=0.
